cv32e41p_hwloop_seq: RTL and testbench

CV32E41P_HWLOOP_SEQ -- requirements
Module: cv32e41p_hwloop_seq

---
 rtl/cv32e41p_hwloop_seq.sv | 188 ++++++++++++++++++
 tb/tb_cv32e41p_hwloop_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_hwloop_seq.sv
// ---------------------------------------------------------------------------
// cv32e41p_hwloop_seq
//
// Hardware-loop sequencer. It watches the PC of the instruction in ID. When
// that PC hits the end address of an active loop (counter != 0), it asks the
// loop registers to decrement that loop's counter. If the loop is not on its
// last iteration (counter != 1), it also asks prefetch to jump to the loop's
// start address. Loop 0 is the innermost loop and wins when several loops
// end on the same PC.
//
// Build option:
//   CV32E41P_HWLP_ERR_EN - when defined, hwlp_err_o is a registered one-cycle
//                          pulse that flags more than one loop matching in
//                          IDLE. When undefined, hwlp_err_o is tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   current_pc_i/pc_valid_i PC of the ID instruction and its valid flag
//   id_retire_i            ID instruction leaves ID this cycle
//   flush_i                exception/debug/branch flush (highest priority)
//   hwlp_start_addr_i      per-loop start addresses  [N_REGS][32]
//   hwlp_end_addr_i        per-loop end addresses    [N_REGS][32]
//   hwlp_counter_i         per-loop iteration counts [N_REGS][32]
//   hwlp_dec_cnt_o         one-hot counter decrement request
//   hwlp_jump_o            jump request to prefetch (held in REQ)
//   hwlp_targ_addr_o       jump target, stable while the jump is pending
//   jump_ack_i             prefetch accepted the jump
//   hwlp_busy_o            sequencer is not idle
//   hwlp_err_o             ambiguous loop match (optional)
// ---------------------------------------------------------------------------

// Per-loop end-of-body detector.
module cv32e41p_hwloop_match (
  input  logic [31:0] i_pc,
  input  logic        i_pc_valid,
  input  logic [31:0] i_end_addr,
  input  logic [31:0] i_counter,
  output logic        o_match
);
  assign o_match = i_pc_valid && (i_pc == i_end_addr) && (i_counter != 32'd0);
endmodule

module cv32e41p_hwloop_seq #(
  parameter int N_REGS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            current_pc_i,
  input  logic                   pc_valid_i,
  input  logic                   id_retire_i,
  input  logic                   flush_i,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
  output logic                   hwlp_jump_o,
  output logic [31:0]            hwlp_targ_addr_o,
  input  logic                   jump_ack_i,
  output logic                   hwlp_busy_o,
  output logic                   hwlp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RET = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_retired, w_retired_nxt;
  logic                w_load_targ;
  logic [31:0]         r_targ;
  logic [N_REGS-1:0]   w_match;
  logic [N_REGS-1:0]   w_sel_oh;
  logic                w_any;
  logic                w_take;
  logic [31:0]         w_sel_start;
  logic [31:0]         w_sel_cnt;

  // -------------------------------------------------------------------------
  // Per-loop match
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < N_REGS; g++) begin : g_loop
    cv32e41p_hwloop_match u_match (
      .i_pc       (current_pc_i),
      .i_pc_valid (pc_valid_i),
      .i_end_addr (hwlp_end_addr_i[g]),
      .i_counter  (hwlp_counter_i[g]),
      .o_match    (w_match[g])
    );
  end

  assign w_any = |w_match;

  // Isolate the lowest set bit: loop 0 (innermost) has priority.
  assign w_sel_oh = w_match & (~w_match + N_REGS'(1));

  // AND-OR mux of the selected loop's start address and counter.
  always_comb begin
    w_sel_start = '0;
    w_sel_cnt   = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (w_sel_oh[k]) begin
        w_sel_start = w_sel_start | hwlp_start_addr_i[k];
        w_sel_cnt   = w_sel_cnt   | hwlp_counter_i[k];
      end
    end
  end

  // Counter 1 means this is the last pass: decrement, but fall through.
  assign w_take = w_any && (w_sel_cnt != 32'd1);

  // Decrement only from IDLE, so a stalled end instruction (held in ID while
  // we wait for ack/retire) is counted exactly once.
  assign hwlp_dec_cnt_o = (r_state == S_IDLE && w_any) ? w_sel_oh : '0;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_retired_nxt = r_retired;
    w_load_targ   = 1'b0;
    if (flush_i) begin
      w_state_nxt   = S_IDLE;
      w_retired_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            w_load_targ   = 1'b1;
            w_retired_nxt = id_retire_i;
            w_state_nxt   = S_REQ;
          end
        end
        S_REQ: begin
          if (jump_ack_i) begin
            // The end instruction may still be in ID; wait for it to leave
            // so it is not detected a second time.
            w_state_nxt   = (r_retired || id_retire_i) ? S_IDLE : S_WAIT_RET;
            w_retired_nxt = 1'b0;
          end else if (id_retire_i) begin
            w_retired_nxt = 1'b1;
          end
        end
        S_WAIT_RET: begin
          if (id_retire_i) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_retired_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_retired <= 1'b0;
      r_targ    <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_retired <= w_retired_nxt;
      if (w_load_targ) r_targ <= w_sel_start;
    end
  end

  assign hwlp_jump_o      = (r_state == S_REQ);
  assign hwlp_targ_addr_o = r_targ;
  assign hwlp_busy_o      = (r_state != S_IDLE);

  // -------------------------------------------------------------------------
  // Ambiguous-match flag
  // -------------------------------------------------------------------------
`ifdef CV32E41P_HWLP_ERR_EN
  logic r_err;
  // More than one bit set: clearing the lowest set bit leaves something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (r_state == S_IDLE) && |(w_match & (w_match - N_REGS'(1)));
  end
  assign hwlp_err_o = r_err;
`else
  assign hwlp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e41p_hwloop_seq.sv
// ---------------------------------------------------------------------------
// Directed bench for cv32e41p_hwloop_seq (N_REGS = 2). Inputs change 1 time
// unit after a rising edge; outputs are sampled there too, away from edges.
// ---------------------------------------------------------------------------
module tb_cv32e41p_hwloop_seq;

  logic              clk;
  logic              rst_n;
  logic [31:0]       current_pc_i;
  logic              pc_valid_i;
  logic              id_retire_i;
  logic              flush_i;
  logic [1:0][31:0]  hwlp_start_addr_i;
  logic [1:0][31:0]  hwlp_end_addr_i;
  logic [1:0][31:0]  hwlp_counter_i;
  logic [1:0]        hwlp_dec_cnt_o;
  logic              hwlp_jump_o;
  logic [31:0]       hwlp_targ_addr_o;
  logic              jump_ack_i;
  logic              hwlp_busy_o;
  logic              hwlp_err_o;

  int n_chk;
  int n_err;

`ifdef CV32E41P_HWLP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  cv32e41p_hwloop_seq #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_pc_i      (current_pc_i),
    .pc_valid_i        (pc_valid_i),
    .id_retire_i       (id_retire_i),
    .flush_i           (flush_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
    .hwlp_jump_o       (hwlp_jump_o),
    .hwlp_targ_addr_o  (hwlp_targ_addr_o),
    .jump_ack_i        (jump_ack_i),
    .hwlp_busy_o       (hwlp_busy_o),
    .hwlp_err_o        (hwlp_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pc_valid_i  = 1'b0;
    id_retire_i = 1'b0;
    jump_ack_i  = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Present the loop-0 end PC with counter 3 and no retire; lands in REQ.
  task automatic enter_req();
    hwlp_end_addr_i[0]   = 32'h100;
    hwlp_start_addr_i[0] = 32'h80;
    hwlp_counter_i[0]    = 32'd3;
    hwlp_counter_i[1]    = 32'd0;
    current_pc_i = 32'h100;
    pc_valid_i   = 1'b1;
    id_retire_i  = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    current_pc_i = 32'h0;
    hwlp_start_addr_i = '0;
    hwlp_end_addr_i   = '0;
    hwlp_counter_i    = '0;
    idle_in();
    #12;
    chk("rst_jump", {31'b0, hwlp_jump_o}, 32'd0);
    chk("rst_targ", hwlp_targ_addr_o, 32'h0);
    chk("rst_busy", {31'b0, hwlp_busy_o}, 32'd0);
    chk("rst_err",  {31'b0, hwlp_err_o}, 32'd0);
    chk("rst_dec",  {30'b0, hwlp_dec_cnt_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic jump, end instruction retires in the detection cycle.
    hwlp_end_addr_i[0] = 32'h100; hwlp_start_addr_i[0] = 32'h80; hwlp_counter_i[0] = 32'd3;
    hwlp_end_addr_i[1] = 32'hFF0; hwlp_start_addr_i[1] = 32'h40; hwlp_counter_i[1] = 32'd0;
    current_pc_i = 32'h100; pc_valid_i = 1'b1; id_retire_i = 1'b1;
    #1;
    chk("basic_dec",   {30'b0, hwlp_dec_cnt_o}, 32'h1);
    chk("basic_nojmp", {31'b0, hwlp_jump_o}, 32'd0);
    tick();
    chk("basic_jump", {31'b0, hwlp_jump_o}, 32'd1);
    chk("basic_targ", hwlp_targ_addr_o, 32'h80);
    chk("basic_busy", {31'b0, hwlp_busy_o}, 32'd1);
    chk("basic_err",  {31'b0, hwlp_err_o}, 32'd0);
    chk("basic_dec2", {30'b0, hwlp_dec_cnt_o}, 32'h0);
    pc_valid_i = 1'b0; id_retire_i = 1'b0; jump_ack_i = 1'b1;
    tick();
    jump_ack_i = 1'b0;
    chk("basic_idle", {31'b0, hwlp_busy_o}, 32'd0);
    chk("basic_jmp0", {31'b0, hwlp_jump_o}, 32'd0);

    // Loop exit: counter 1 decrements but does not jump.
    hwlp_counter_i[0] = 32'd1;
    current_pc_i = 32'h100; pc_valid_i = 1'b1; id_retire_i = 1'b1;
    #1;
    chk("exit_dec", {30'b0, hwlp_dec_cnt_o}, 32'h1);
    tick();
    chk("exit_jump", {31'b0, hwlp_jump_o}, 32'd0);
    chk("exit_busy", {31'b0, hwlp_busy_o}, 32'd0);

    // Counter 0: no match at all.
    hwlp_counter_i[0] = 32'd0;
    #1;
    chk("zero_dec", {30'b0, hwlp_dec_cnt_o}, 32'h0);
    tick();
    chk("zero_busy", {31'b0, hwlp_busy_o}, 32'd0);
    idle_in();

    // pc_valid low masks the match.
    hwlp_counter_i[0] = 32'd3;
    #1;
    chk("nvalid_dec", {30'b0, hwlp_dec_cnt_o}, 32'h0);
    tick();

    // Stall: end PC held 4 cycles, ack in cycle 3, retire in cycle 4.
    hwlp_counter_i[0] = 32'd5;
    current_pc_i = 32'h100; pc_valid_i = 1'b1;
    #1;
    chk("stall_dec_c1", {30'b0, hwlp_dec_cnt_o}, 32'h1);
    tick();
    chk("stall_dec_c2",  {30'b0, hwlp_dec_cnt_o}, 32'h0);
    chk("stall_jump_c2", {31'b0, hwlp_jump_o}, 32'd1);
    tick();
    chk("stall_jump_c3", {31'b0, hwlp_jump_o}, 32'd1);
    jump_ack_i = 1'b1;
    tick();
    jump_ack_i = 1'b0;
    chk("stall_jump_c4", {31'b0, hwlp_jump_o}, 32'd0);
    chk("stall_wait",    {31'b0, hwlp_busy_o}, 32'd1);
    chk("stall_dec_c4",  {30'b0, hwlp_dec_cnt_o}, 32'h0);
    id_retire_i = 1'b1;
    tick();
    idle_in();
    chk("stall_done", {31'b0, hwlp_busy_o}, 32'd0);

    // Retire before ack: remembered, so ack returns straight to IDLE.
    enter_req();
    id_retire_i = 1'b1;
    tick();
    pc_valid_i = 1'b0; id_retire_i = 1'b0;
    chk("ret_first_req", {31'b0, hwlp_jump_o}, 32'd1);
    jump_ack_i = 1'b1;
    tick();
    jump_ack_i = 1'b0;
    chk("ret_first_idle", {31'b0, hwlp_busy_o}, 32'd0);

    // Nested loops sharing an end PC: loop 0 wins.
    hwlp_end_addr_i[0] = 32'h200; hwlp_start_addr_i[0] = 32'h180; hwlp_counter_i[0] = 32'd2;
    hwlp_end_addr_i[1] = 32'h200; hwlp_start_addr_i[1] = 32'h140; hwlp_counter_i[1] = 32'd4;
    current_pc_i = 32'h200; pc_valid_i = 1'b1; id_retire_i = 1'b1;
    #1;
    chk("nest_dec", {30'b0, hwlp_dec_cnt_o}, 32'h1);
    tick();
    pc_valid_i = 1'b0; id_retire_i = 1'b0;
    chk("nest_targ", hwlp_targ_addr_o, 32'h180);
    chk("nest_err",  {31'b0, hwlp_err_o}, {31'b0, ERR_EXP});
    jump_ack_i = 1'b1;
    tick();
    jump_ack_i = 1'b0;
    chk("nest_err_end", {31'b0, hwlp_err_o}, 32'd0);
    chk("nest_idle",    {31'b0, hwlp_busy_o}, 32'd0);

    // Only loop 1 active, large unsigned counter still takes.
    hwlp_counter_i[0] = 32'd0; hwlp_counter_i[1] = 32'hFFFF_FFFF;
    pc_valid_i = 1'b1; id_retire_i = 1'b1;
    #1;
    chk("l1_dec", {30'b0, hwlp_dec_cnt_o}, 32'h2);
    tick();
    pc_valid_i = 1'b0; id_retire_i = 1'b0;
    chk("l1_targ", hwlp_targ_addr_o, 32'h140);
    chk("l1_jump", {31'b0, hwlp_jump_o}, 32'd1);
    chk("l1_err",  {31'b0, hwlp_err_o}, 32'd0);
    jump_ack_i = 1'b1;
    tick();
    jump_ack_i = 1'b0;

    // Flush in REQ: jump drops next cycle, target kept.
    enter_req();
    pc_valid_i = 1'b0;
    chk("flush_pre", {31'b0, hwlp_jump_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_jump", {31'b0, hwlp_jump_o}, 32'd0);
    chk("flush_busy", {31'b0, hwlp_busy_o}, 32'd0);
    chk("flush_targ", hwlp_targ_addr_o, 32'h80);

    // Flush in IDLE blocks a new jump.
    hwlp_start_addr_i[0] = 32'h60;
    pc_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    idle_in();
    chk("flush_idle_jump", {31'b0, hwlp_jump_o}, 32'd0);
    chk("flush_idle_targ", hwlp_targ_addr_o, 32'h80);

    // Reset mid-REQ: immediate reset values, no jump after release.
    hwlp_start_addr_i[0] = 32'h80;
    enter_req();
    pc_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rreq_jump", {31'b0, hwlp_jump_o}, 32'd0);
    chk("rreq_targ", hwlp_targ_addr_o, 32'h0);
    chk("rreq_busy", {31'b0, hwlp_busy_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rreq_after", {31'b0, hwlp_jump_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
